// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite slave between NUM_REQ simple requesters.
// One transaction is in flight at a time; the response returns only to the granted requester.
module axi_lite_req_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic [1:0]                     rsp_resp,
    output logic [ADDR_WIDTH-1:0]          AWADDR,
    output logic                           AWVALID,
    input  logic                           AWREADY,
    output logic [DATA_WIDTH-1:0]          WDATA,
    output logic [STRB_WIDTH-1:0]          WSTRB,
    output logic                           WVALID,
    input  logic                           WREADY,
    input  logic [1:0]                     BRESP,
    input  logic                           BVALID,
    output logic                           BREADY,
    output logic [ADDR_WIDTH-1:0]          ARADDR,
    output logic                           ARVALID,
    input  logic                           ARREADY,
    input  logic [DATA_WIDTH-1:0]          RDATA,
    input  logic [1:0]                     RRESP,
    input  logic                           RVALID,
    output logic                           RREADY
);

    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [IDXW-1:0]         last_grant_q, last_grant_d;
    logic [IDXW-1:0]         grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;

    logic                    win_found;
    logic [IDXW-1:0]         win_idx;

    function automatic logic [IDXW-1:0] wrap_idx(input int v);
        return IDXW'(v % NUM_REQ);
    endfunction

    // Scan starts one past the last winner, so an idle requester costs nothing.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && req_valid[wrap_idx(int'(last_grant_q) + k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_idx(int'(last_grant_q) + k);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            last_grant_q <= IDXW'(NUM_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        req_ready    = '0;

        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    grant_d      = win_idx;
                    last_grant_d = win_idx;
                    addr_d       = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d      = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    wstrb_d      = req_wstrb[win_idx*STRB_WIDTH +: STRB_WIDTH];
                    aw_done_d    = 1'b0;
                    w_done_d     = 1'b0;
                    state_d      = req_write[win_idx] ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                // AW and W complete independently, so slaves ordering them either way progress.
                aw_done_d = aw_done_q | AWREADY;
                w_done_d  = w_done_q | WREADY;
                if ((aw_done_q | AWREADY) && (w_done_q | WREADY)) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (BVALID) begin
                    resp_d  = BRESP;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            RD_REQ: begin
                if (ARREADY) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (RVALID) begin
                    rdata_d = RDATA;
                    resp_d  = RRESP;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign AWADDR    = addr_q;
    assign ARADDR    = addr_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign AWVALID   = (state_q == WR_REQ) && !aw_done_q;
    assign WVALID    = (state_q == WR_REQ) && !w_done_q;
    assign BREADY    = (state_q == WR_RESP);
    assign ARVALID   = (state_q == RD_REQ);
    assign RREADY    = (state_q == RD_RESP);
    assign rsp_valid = (state_q == DONE) ? (NUM_REQ'(1) << grant_q) : '0;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

endmodule
